// File: rtl/ls161_div_ctrl.sv
// ls161_div_ctrl: runs an external '161 4-bit counter as a programmable modulo-N divider.
// Define LS161_SHADOW_CHECK_EN to add a shadow counter that flags Q_IN mismatches on ERR.
module ls161_div_ctrl (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       START,
    input  logic       STOP,
    input  logic       ONESHOT,
    input  logic [3:0] N,
    input  logic [3:0] Q_IN,
    input  logic       RCO_IN,
    output logic [3:0] D,
    output logic       LOAD_n,
    output logic       ENP,
    output logic       ENT,
    output logic       TICK,
    output logic       DONE,
    output logic       BUSY,
    output logic       ERR
);
    // state | meaning
    // IDLE  | counter frozen, waiting for START
    // LOAD  | one cycle parallel load of the preload value
    // RUN   | counting; reload or stop on terminal count
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] preload;
    logic       oneshot_lat;
    logic       go;
    logic       term;
    logic       reload;
    logic       os_exit;

    assign go      = (state == IDLE) && START && !STOP;
    assign term    = (state == RUN) && RCO_IN && !STOP;
    assign reload  = term && !oneshot_lat;
    assign os_exit = term && oneshot_lat;
    assign D       = preload;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // N and ONESHOT are captured at START so mid-run changes wait for the next run.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            preload     <= 4'd0;
            oneshot_lat <= 1'b0;
            TICK        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            if (go) begin
                preload     <= 4'd0 - N;
                oneshot_lat <= ONESHOT;
            end
            TICK <= term;
            DONE <= os_exit;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START && !STOP) state_nxt = LOAD;
            LOAD:    state_nxt = STOP ? IDLE : RUN;
            RUN:     if (STOP || os_exit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        LOAD_n = 1'b1;
        ENP    = 1'b0;
        ENT    = 1'b0;
        BUSY   = 1'b0;
        case (state)
            LOAD: begin
                BUSY   = 1'b1;
                LOAD_n = STOP;
            end
            RUN: begin
                BUSY   = 1'b1;
                LOAD_n = !reload;
                // one-shot terminal count holds the counter at 15
                if (!STOP && !os_exit) begin
                    ENP = 1'b1;
                    ENT = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef LS161_SHADOW_CHECK_EN
    logic [3:0] shadow_q;
    logic       err_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            shadow_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            if (!LOAD_n) begin
                shadow_q <= preload;
            end else if (ENP && ENT) begin
                shadow_q <= shadow_q + 4'd1;
            end
            if ((state == RUN) && (Q_IN != shadow_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ERR = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = ^Q_IN;
    assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_ls161_div_ctrl.sv
// Bench for ls161_div_ctrl: a '161 counter plant plus a period/position reference model.
module tb_ls161_div_ctrl;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       CLR, START, STOP, ONESHOT, RCO_IN;
    logic [3:0] N, Q_IN, D;
    logic       LOAD_n, ENP, ENT, TICK, DONE, BUSY, ERR;

    ls161_div_ctrl dut (
        .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP), .ONESHOT(ONESHOT),
        .N(N), .Q_IN(Q_IN), .RCO_IN(RCO_IN), .D(D), .LOAD_n(LOAD_n),
        .ENP(ENP), .ENT(ENT), .TICK(TICK), .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
    );

    // '161 counter plant; glitch forces the Q bus to 0 without disturbing the counter
    logic [3:0] cnt_q  = 4'd0;
    logic       glitch = 1'b0;
    always @(posedge CLK) begin
        if (!LOAD_n) cnt_q <= D;
        else if (ENP && ENT) cnt_q <= cnt_q + 4'd1;
    end
    assign Q_IN   = glitch ? 4'd0 : cnt_q;
    assign RCO_IN = (cnt_q == 4'd15);

`ifdef LS161_SHADOW_CHECK_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // reference model: mode 0 idle, 1 loading, 2 running; k = cycles into current period
    int         m_mode = 0;
    int         m_period = 16;
    int         m_k = 0;
    logic [3:0] m_p = 4'd0;
    logic       m_os = 1'b0;
    logic       m_tick = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    bit         m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit rco;
        int exp_loadn, exp_en, exp_busy;
        rco       = (m_mode == 2) && (m_k == m_period - 1);
        exp_loadn = 1;
        exp_en    = 0;
        exp_busy  = (m_mode != 0) ? 1 : 0;
        if (m_mode == 1) begin
            exp_loadn = STOP ? 1 : 0;
        end else if (m_mode == 2 && !STOP) begin
            if (rco && !m_os) begin
                exp_loadn = 0;
                exp_en    = 1;
            end else if (!rco) begin
                exp_en = 1;
            end
        end
        chk("D", D, m_p);
        chk("LOAD_n", LOAD_n, exp_loadn);
        chk("ENP", ENP, exp_en);
        chk("ENT", ENT, exp_en);
        chk("BUSY", BUSY, exp_busy);
        chk("TICK", TICK, m_tick);
        chk("DONE", DONE, m_done);
        chk("ERR", ERR, m_err);
        if (m_mode == 2 && !glitch) chk("Q", Q_IN, (m_p + m_k) % 16);
    endtask

    task automatic model_step();
        bit rco;
        rco = (m_mode == 2) && (m_k == m_period - 1);
        if (CLR) begin
            m_mode  = 0;
            m_p     = 4'd0;
            m_tick  = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (SHADOW && m_mode == 2 && glitch && ((m_p + m_k) % 16) != 0) m_err = 1'b1;
            m_tick = rco && !STOP;
            m_done = rco && m_os && !STOP;
            case (m_mode)
                0: if (START && !STOP) begin
                    m_p      = 4'(16 - int'(N));
                    m_period = (N == 4'd0) ? 16 : int'(N);
                    m_os     = ONESHOT;
                    m_mode   = 1;
                end
                1: begin
                    if (STOP) m_mode = 0;
                    else begin
                        m_mode = 2;
                        m_k    = 0;
                    end
                end
                default: begin
                    if (STOP) m_mode = 0;
                    else if (rco) begin
                        if (m_os) m_mode = 0;
                        else m_k = 0;
                    end else m_k++;
                end
            endcase
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic step(input bit clr, input bit start, input bit stop, input bit os,
                        input logic [3:0] n);
        CLR = clr; START = start; STOP = stop; ONESHOT = os; N = n;
        #1;
        if (m_valid) compare_model();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    int         ticks;
    bit         r_clr, r_start, r_stop, r_os;
    logic [3:0] r_n;

    initial begin
        CLR = 1'b1; START = 1'b0; STOP = 1'b0; ONESHOT = 1'b0; N = 4'd0;
        @(negedge CLK);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_D", D, 0);
        chk("rst_BUSY", BUSY, 0);
        chk("rst_LOAD_n", LOAD_n, 1);
        chk("rst_ENP", ENP, 0);
        chk("rst_TICK", TICK, 0);
        chk("rst_ERR", ERR, 0);

        // N=5 continuous
        step(0, 1, 0, 0, 5);
        chk("n5_D", D, 11);
        chk("n5_load_low", LOAD_n, 0);
        step(0, 0, 0, 0, 9);
        chk("n5_q_first", Q_IN, 11);
        ticks = 0;
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 2);
            ticks += int'(TICK);
        end
        chk("n5_ticks", ticks, 3);
        chk("n5_q_end", Q_IN, 11);
        step(0, 0, 1, 0, 5);
        chk("n5_stop_busy", BUSY, 0);

        // N=0 gives 16, N=1 gives every cycle
        step(0, 1, 0, 0, 0);
        chk("n0_D", D, 0);
        step(0, 0, 0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 0);
            ticks += int'(TICK);
        end
        chk("n0_ticks", ticks, 2);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1);
        chk("n1_D", D, 15);
        step(0, 0, 0, 0, 1);
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            ticks += int'(TICK);
        end
        chk("n1_ticks", ticks, 4);
        step(0, 0, 1, 0, 1);

        // N=3 one-shot
        step(0, 1, 0, 1, 3);
        step(0, 0, 0, 1, 3);
        chk("os_q13", Q_IN, 13);
        step(0, 0, 0, 1, 3);
        chk("os_q14", Q_IN, 14);
        step(0, 0, 0, 1, 3);
        chk("os_q15", Q_IN, 15);
        step(0, 0, 0, 1, 3);
        chk("os_done", DONE, 1);
        chk("os_tick", TICK, 1);
        chk("os_busy", BUSY, 0);
        step(0, 0, 0, 1, 3);
        chk("os_done_once", DONE, 0);
        chk("os_no_tick2", TICK, 0);
        chk("os_q_hold", Q_IN, 15);

        // STOP at Q=12 with N=6
        step(0, 1, 0, 0, 6);
        step(0, 0, 0, 0, 6);
        step(0, 0, 0, 0, 6);
        step(0, 0, 0, 0, 6);
        chk("stop_q12", Q_IN, 12);
        step(0, 0, 1, 0, 6);
        chk("stop_frozen", Q_IN, 12);
        chk("stop_no_tick", TICK, 0);
        chk("stop_idle", BUSY, 0);
        step(0, 0, 0, 0, 6);
        chk("stop_still", Q_IN, 12);
        step(0, 1, 0, 0, 6);
        chk("restart_D", D, 10);
        step(0, 0, 0, 0, 6);
        chk("restart_q", Q_IN, 10);

        // CLR mid-run together with START
        step(0, 0, 0, 0, 6);
        step(1, 1, 0, 0, 6);
        chk("clr_busy", BUSY, 0);
        chk("clr_D", D, 0);
        chk("clr_tick", TICK, 0);
        chk("clr_load_n", LOAD_n, 1);
        chk("clr_enp", ENP, 0);
        step(0, 0, 0, 0, 6);
        chk("clr_start_ignored", BUSY, 0);

        // Q bus corruption for one RUN cycle
        step(0, 1, 0, 0, 5);
        step(0, 0, 0, 0, 5);
        glitch = 1'b1;
        step(0, 0, 0, 0, 5);
        glitch = 1'b0;
        chk("err_set", ERR, SHADOW ? 1 : 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5);
        chk("err_sticky", ERR, SHADOW ? 1 : 0);
        step(1, 0, 0, 0, 5);
        chk("err_clr", ERR, 0);

        // randomized traffic against the model
        r_os = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_clr   = ($urandom_range(0, 99) < 2);
            r_start = ($urandom_range(0, 99) < 20);
            r_stop  = ($urandom_range(0, 99) < 3);
            r_n     = 4'($urandom_range(0, 15));
            if (m_mode == 0) r_os = 1'($urandom_range(0, 1));
            step(r_clr, r_start, r_stop, r_os, r_n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
